// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the program counter, drives the IRAM read port,
// waits out the read latency, then strobes the MBRU and flags the new instruction.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                RAM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              fetch_req,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] iram_addr,
    output logic              iram_en,
    output logic              mbru_fetch,
    output logic              ins_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              running
);

    localparam int                CNT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAM_LAT - 1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_IDLE  = 2'b01,
        ST_READ  = 2'b10,
        ST_LATCH = 2'b11
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              jump_pend_r, jump_pend_s;
    logic [ADDR_W-1:0] jump_addr_r, jump_addr_s;
    logic              halt_pend_r, halt_pend_s;
    logic              ins_valid_r, ins_valid_s;
    logic              iram_en_r, iram_en_s;
    logic              mbru_fetch_r, mbru_fetch_s;
    logic              busy_r, busy_s;
    logic              running_r, running_s;

    // Next-state, pc update and pending jump/halt capture.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        cnt_s       = cnt_r;
        jump_pend_s = jump_pend_r;
        jump_addr_s = jump_addr_r;
        halt_pend_s = halt_pend_r;
        ins_valid_s = 1'b0;

        case (state_r)
            ST_STOP: begin
                if (jump) begin
                    pc_s = jump_addr;
                end else begin
                    pc_s = pc_r;
                end
                if (start) begin
                    state_s = ST_READ;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_IDLE: begin
                if (jump) begin
                    pc_s = jump_addr;
                end else begin
                    pc_s = pc_r;
                end
                // halt has priority so a simultaneous request never starts a fetch
                if (halt) begin
                    state_s = ST_STOP;
                end else if (fetch_req) begin
                    state_s = ST_READ;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (jump) begin
                    jump_pend_s = 1'b1;
                    jump_addr_s = jump_addr;
                end else begin
                    jump_pend_s = jump_pend_r;
                end
                if (halt) begin
                    halt_pend_s = 1'b1;
                end else begin
                    halt_pend_s = halt_pend_r;
                end
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_LATCH;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_READ;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_LATCH: begin
                ins_valid_s = 1'b1;
                // a jump seen this cycle is newer than one captured during READ
                if (jump) begin
                    pc_s = jump_addr;
                end else if (jump_pend_r) begin
                    pc_s = jump_addr_r;
                end else begin
                    pc_s = pc_r + PC_ONE;
                end
                if (halt_pend_r || halt) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_IDLE;
                end
                jump_pend_s = 1'b0;
                halt_pend_s = 1'b0;
            end
            default: begin
                state_s     = ST_STOP;
                jump_pend_s = 1'b0;
                halt_pend_s = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        iram_en_s    = 1'b0;
        mbru_fetch_s = 1'b0;
        busy_s       = 1'b0;
        running_s    = 1'b0;
        case (state_s)
            ST_STOP: begin
                running_s = 1'b0;
            end
            ST_IDLE: begin
                running_s = 1'b1;
            end
            ST_READ: begin
                iram_en_s = 1'b1;
                busy_s    = 1'b1;
                running_s = 1'b1;
            end
            ST_LATCH: begin
                mbru_fetch_s = 1'b1;
                busy_s       = 1'b1;
                running_s    = 1'b1;
            end
            default: begin
                running_s = 1'b0;
            end
        endcase
    end

    // State, pc and registered outputs; reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_STOP;
            pc_r         <= RESET_PC;
            cnt_r        <= CNT_ZERO;
            jump_pend_r  <= 1'b0;
            jump_addr_r  <= {ADDR_W{1'b0}};
            halt_pend_r  <= 1'b0;
            ins_valid_r  <= 1'b0;
            iram_en_r    <= 1'b0;
            mbru_fetch_r <= 1'b0;
            busy_r       <= 1'b0;
            running_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            cnt_r        <= cnt_s;
            jump_pend_r  <= jump_pend_s;
            jump_addr_r  <= jump_addr_s;
            halt_pend_r  <= halt_pend_s;
            ins_valid_r  <= ins_valid_s;
            iram_en_r    <= iram_en_s;
            mbru_fetch_r <= mbru_fetch_s;
            busy_r       <= busy_s;
            running_r    <= running_s;
        end
    end

    assign iram_addr  = pc_r;
    assign pc         = pc_r;
    assign iram_en    = iram_en_r;
    assign mbru_fetch = mbru_fetch_r;
    assign ins_valid  = ins_valid_r;
    assign busy       = busy_r;
    assign running    = running_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: one instance with RAM_LAT=1 and one with RAM_LAT=3,
// each feeding a behavioural IRAM and MBRU; fetch results are scoreboarded.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_s     [2];
    logic       halt_s      [2];
    logic       fetch_req_s [2];
    logic       jump_s      [2];
    logic [7:0] jump_addr_s [2];
    logic [7:0] iram_addr_s [2];
    logic       iram_en_s   [2];
    logic       mbru_fetch_s[2];
    logic       ins_valid_s [2];
    logic [7:0] pc_s        [2];
    logic       busy_s      [2];
    logic       running_s   [2];

    logic [7:0] iram [256];
    logic [7:0] rd1_q;
    logic [7:0] rd3_q [3];
    logic [7:0] mbru_s [2];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_chk = 0;

    typedef struct {
        logic       use_start;
        logic       jmp;
        logic [7:0] ja;
        logic       mid_jump;
        logic [7:0] mid_ja;
        logic       mid_halt;
        logic [7:0] exp_addr;
        logic [7:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    fetch_sequencer #(.ADDR_W(8), .RAM_LAT(1), .RESET_PC(8'h00)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .halt(halt_s[0]),
        .fetch_req(fetch_req_s[0]), .jump(jump_s[0]), .jump_addr(jump_addr_s[0]),
        .iram_addr(iram_addr_s[0]), .iram_en(iram_en_s[0]), .mbru_fetch(mbru_fetch_s[0]),
        .ins_valid(ins_valid_s[0]), .pc(pc_s[0]), .busy(busy_s[0]), .running(running_s[0])
    );

    fetch_sequencer #(.ADDR_W(8), .RAM_LAT(3), .RESET_PC(8'h00)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .halt(halt_s[1]),
        .fetch_req(fetch_req_s[1]), .jump(jump_s[1]), .jump_addr(jump_addr_s[1]),
        .iram_addr(iram_addr_s[1]), .iram_en(iram_en_s[1]), .mbru_fetch(mbru_fetch_s[1]),
        .ins_valid(ins_valid_s[1]), .pc(pc_s[1]), .busy(busy_s[1]), .running(running_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [7:0] a);
        return (a == 8'h00) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    // IRAM read pipelines (data only valid if en held for the full latency) and MBRUs
    always @(posedge clk) begin
        rd1_q    <= iram_en_s[0] ? iram[iram_addr_s[0]] : 8'h00;
        rd3_q[0] <= iram_en_s[1] ? iram[iram_addr_s[1]] : 8'h00;
        rd3_q[1] <= iram_en_s[1] ? rd3_q[0] : 8'h00;
        rd3_q[2] <= iram_en_s[1] ? rd3_q[1] : 8'h00;
        if (mbru_fetch_s[0]) mbru_s[0] <= rd1_q;
        if (mbru_fetch_s[1]) mbru_s[1] <= rd3_q[2];
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_idle_outs(input int d, input logic [7:0] exp_pc, input string tag);
        chk({tag, " iram_en"}, iram_en_s[d], 1'b0);
        chk({tag, " mbru_fetch"}, mbru_fetch_s[d], 1'b0);
        chk({tag, " ins_valid"}, ins_valid_s[d], 1'b0);
        chk({tag, " busy"}, busy_s[d], 1'b0);
        chk({tag, " running"}, running_s[d], 1'b0);
        chk({tag, " pc"}, pc_s[d], exp_pc);
    endtask

    // One complete fetch, called at a negedge with the DUT in STOP (use_start) or IDLE.
    task automatic run_fetch(input int d, input vec_t v, output int iv_cyc);
        int   lat;
        exp_t e;
        lat    = (d == 0) ? 1 : 3;
        e.data = mem_val(v.exp_addr);
        e.pc   = v.exp_pc;
        sb.push_back(e);
        if (v.use_start) start_s[d] = 1'b1;
        else             fetch_req_s[d] = 1'b1;
        jump_s[d]      = v.jmp;
        jump_addr_s[d] = v.ja;
        @(negedge clk);
        start_s[d]     = 1'b0;
        fetch_req_s[d] = 1'b0;
        jump_s[d]      = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk("read iram_en", iram_en_s[d], 1'b1);
            chk("read iram_addr", iram_addr_s[d], v.exp_addr);
            chk("read busy", busy_s[d], 1'b1);
            chk("read mbru_fetch", mbru_fetch_s[d], 1'b0);
            // first READ jump is a decoy that the last one must overwrite
            if (v.mid_jump && (i == lat - 1 || i == 0)) begin
                jump_s[d]      = 1'b1;
                jump_addr_s[d] = (i == lat - 1) ? v.mid_ja : ~v.mid_ja;
            end
            if (v.mid_halt && i == 0) halt_s[d] = 1'b1;
            @(negedge clk);
            jump_s[d] = 1'b0;
            halt_s[d] = 1'b0;
        end
        chk("latch mbru_fetch", mbru_fetch_s[d], 1'b1);
        chk("latch iram_en", iram_en_s[d], 1'b0);
        chk("latch busy", busy_s[d], 1'b1);
        @(negedge clk);
        chk("ins_valid", ins_valid_s[d], 1'b1);
        chk("mbru_fetch drop", mbru_fetch_s[d], 1'b0);
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("mbru data", mbru_s[d], e.data);
            chk("pc after", pc_s[d], e.pc);
        end
        chk("running after", running_s[d], !v.mid_halt);
        iv_cyc = cyc;
    endtask

    initial begin
        int   iv1, iv2, ivx;
        vec_t v;

        for (int i = 0; i < 256; i++) iram[i] = mem_val(8'(i));
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; halt_s[d] = 1'b0; fetch_req_s[d] = 1'b0;
            jump_s[d] = 1'b0; jump_addr_s[d] = 8'h00; mbru_s[d] = 8'h00;
        end
        // stimulus: use_start jmp ja mid_jump mid_ja mid_halt exp_addr exp_pc
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 8'h02};
        tbl[2] = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h40, 8'h41};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h41, 8'h10};
        tbl[4] = '{1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 8'hFE, 8'hFF};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle_outs(0, 8'h00, "rst1");
        chk_idle_outs(1, 8'h00, "rst3");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outs(1, 8'h00, "post rst3");

        // RAM_LAT=3: start, back-to-back fetch, overwritten jump during READ
        v = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01};
        run_fetch(1, v, iv1);
        v = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 8'h02};
        run_fetch(1, v, iv2);
        chk("ins_valid spacing", iv2 - iv1, 32'd5);
        v = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h02, 8'h40};
        run_fetch(1, v, ivx);
        v = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h40, 8'h41};
        run_fetch(1, v, ivx);

        // RAM_LAT=1: table of back-to-back fetches, ending halted
        for (int i = 0; i < 7; i++) run_fetch(0, tbl[i], ivx);

        // fetch_req while stopped is ignored
        fetch_req_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_outs(0, 8'h01, "stop ignore");
        end
        fetch_req_s[0] = 1'b0;

        // start resumes at current pc
        v = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 8'h02};
        run_fetch(0, v, ivx);

        // halt beats fetch_req in IDLE
        halt_s[0] = 1'b1;
        fetch_req_s[0] = 1'b1;
        @(negedge clk);
        halt_s[0] = 1'b0;
        fetch_req_s[0] = 1'b0;
        chk_idle_outs(0, 8'h02, "halt+req");
        @(negedge clk);
        chk_idle_outs(0, 8'h02, "halt+req later");

        // jump and start together: READ uses the jump target
        v = '{1'b1, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 8'h80, 8'h81};
        run_fetch(0, v, ivx);

        // reset in the middle of a RAM_LAT=3 read
        fetch_req_s[1] = 1'b1;
        @(negedge clk);
        fetch_req_s[1] = 1'b0;
        chk("pre-reset iram_en", iram_en_s[1], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outs(1, 8'h00, "async rst");
        chk("async rst iram_addr", iram_addr_s[1], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_outs(1, 8'h00, "after rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
